// File: rtl/nic8_trace_pkg.sv
// rtl/nic8_trace_pkg.sv - shared types and constants for the NIC8 trace emitter.
// TRACE_CHECKSUM_EN selects a 9-byte frame with a trailing XOR checksum.
package nic8_trace_pkg;

  localparam logic [7:0] TRACE_HEADER = 8'hA5;

`ifdef TRACE_CHECKSUM_EN
  localparam int TRACE_FRAME_LEN = 9;
`else
  localparam int TRACE_FRAME_LEN = 8;
`endif

  localparam int TRACE_IDX_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } trace_state_t;

  typedef struct packed {
    logic [7:0] seq;
    logic [7:0] pc;
    logic [7:0] ir;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] x;
    logic [7:0] q;
  } trace_frame_t;

  // XOR of every byte after the header
  function automatic logic [7:0] trace_checksum(input trace_frame_t f);
    return f.seq ^ f.pc ^ f.ir ^ f.a ^ f.b ^ f.x ^ f.q;
  endfunction

endpackage

// File: rtl/trace_byte_mux.sv
// rtl/trace_byte_mux.sv - selects the frame byte at a given index.
// Index TRACE_FRAME_LEN-1 is the checksum when TRACE_CHECKSUM_EN is defined.
module trace_byte_mux
  import nic8_trace_pkg::*;
#(
  parameter logic [7:0] HEADER = TRACE_HEADER
) (
  input  trace_frame_t           frame_i,
  input  logic [TRACE_IDX_W-1:0] idx_i,
  output logic [7:0]             byte_o
);

  always_comb begin
    byte_o = 8'h00;
    case (idx_i)
      4'd0: byte_o = HEADER;
      4'd1: byte_o = frame_i.seq;
      4'd2: byte_o = frame_i.pc;
      4'd3: byte_o = frame_i.ir;
      4'd4: byte_o = frame_i.a;
      4'd5: byte_o = frame_i.b;
      4'd6: byte_o = frame_i.x;
      4'd7: byte_o = frame_i.q;
`ifdef TRACE_CHECKSUM_EN
      4'd8: byte_o = trace_checksum(frame_i);
`endif
      default: byte_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/trace_emitter.sv
// rtl/trace_emitter.sv - frames NIC8 CPU state snapshots onto a valid/ready byte stream.
// Active + one pending frame; TRACE_CHECKSUM_EN appends an XOR checksum byte.
module trace_emitter
  import nic8_trace_pkg::*;
#(
  parameter logic [7:0] HEADER = TRACE_HEADER
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       step_i,
  input  logic [7:0] pc_i,
  input  logic [7:0] ir_i,
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic [7:0] x_i,
  input  logic [7:0] q_i,
  output logic       out_valid_o,
  output logic [7:0] out_data_o,
  input  logic       out_ready_i,
  output logic       busy_o,
  output logic [7:0] dropped_o
);

  localparam logic [TRACE_IDX_W-1:0] LAST_IDX = TRACE_IDX_W'(TRACE_FRAME_LEN - 1);

  trace_state_t           state_q, state_d;
  logic [TRACE_IDX_W-1:0] idx_q, idx_d;
  trace_frame_t           active_q, active_d;
  trace_frame_t           pend_q, pend_d;
  logic                   pend_full_q, pend_full_d;
  logic [7:0]             seq_q, seq_d;
  logic [7:0]             dropped_q, dropped_d;

  trace_frame_t snap;
  logic         fire;
  logic         free;
  logic [7:0]   mux_byte;

  assign snap = '{seq: seq_q, pc: pc_i, ir: ir_i, a: a_i, b: b_i, x: x_i, q: q_i};
  assign fire = (state_q == SEND) && out_ready_i;
  // The active slot frees up on the very edge its last byte is taken, so frames abut
  assign free = (state_q == IDLE) || (fire && (idx_q == LAST_IDX));

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    active_d    = active_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    seq_d       = seq_q;
    dropped_d   = dropped_q;

    if (step_i) begin
      seq_d = seq_q + 8'd1;
    end

    if (free) begin
      if (pend_full_q) begin
        active_d    = pend_q;
        state_d     = SEND;
        idx_d       = '0;
        pend_full_d = step_i;
        if (step_i) begin
          pend_d = snap;
        end
      end else if (step_i) begin
        active_d = snap;
        state_d  = SEND;
        idx_d    = '0;
      end else begin
        state_d = IDLE;
        idx_d   = '0;
      end
    end else begin
      if (fire) begin
        idx_d = idx_q + 1'b1;
      end
      if (step_i) begin
        if (!pend_full_q) begin
          pend_d      = snap;
          pend_full_d = 1'b1;
        end else if (dropped_q != 8'hFF) begin
          dropped_d = dropped_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      active_q    <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      seq_q       <= 8'd0;
      dropped_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      active_q    <= active_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      seq_q       <= seq_d;
      dropped_q   <= dropped_d;
    end
  end

  trace_byte_mux #(
    .HEADER(HEADER)
  ) u_byte_mux (
    .frame_i(active_q),
    .idx_i  (idx_q),
    .byte_o (mux_byte)
  );

  assign out_valid_o = (state_q == SEND);
  assign out_data_o  = (state_q == SEND) ? mux_byte : 8'h00;
  assign busy_o      = (state_q == SEND) || pend_full_q;
  assign dropped_o   = dropped_q;

endmodule

// File: tb/tb_trace_emitter.sv
// tb/tb_trace_emitter.sv - self-checking bench for trace_emitter against a byte-queue model.
// Honours TRACE_CHECKSUM_EN for frame length and checksum byte.
module tb_trace_emitter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       step = 1'b0;
  logic [7:0] pc = '0, ir = '0, a = '0, b = '0, x = '0, q = '0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [7:0] out_data;
  logic       busy;
  logic [7:0] dropped;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] act[$];
  logic [7:0] pend[$];
  logic [7:0] snap[$];
  bit         pend_v = 1'b0;
  logic [7:0] m_seq  = 8'd0;
  logic [7:0] m_drop = 8'd0;

  always #5 clk = ~clk;

  trace_emitter dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .step_i     (step),
    .pc_i       (pc),
    .ir_i       (ir),
    .a_i        (a),
    .b_i        (b),
    .x_i        (x),
    .q_i        (q),
    .out_valid_o(out_valid),
    .out_data_o (out_data),
    .out_ready_i(out_ready),
    .busy_o     (busy),
    .dropped_o  (dropped)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic build_frame(input logic [7:0] s);
    snap = {8'hA5, s, pc, ir, a, b, x, q};
`ifdef TRACE_CHECKSUM_EN
    snap.push_back(s ^ pc ^ ir ^ a ^ b ^ x ^ q);
`endif
  endtask

  task automatic rand_data();
    pc = 8'($urandom); ir = 8'($urandom); a = 8'($urandom);
    b  = 8'($urandom); x  = 8'($urandom); q = 8'($urandom);
  endtask

  // One clock: drive, advance the model across the edge, then compare all outputs
  task automatic cyc(input bit st, input bit rdy, input bit rst);
    bit had, free;
    step = st; out_ready = rdy; reset = rst;
    @(posedge clk);
    if (rst) begin
      act.delete(); pend.delete(); pend_v = 1'b0; m_seq = 8'd0; m_drop = 8'd0;
    end else begin
      had  = act.size() > 0;
      free = !had || (act.size() == 1 && rdy);
      if (had && rdy) void'(act.pop_front());
      if (st) begin
        build_frame(m_seq);
        m_seq = m_seq + 8'd1;
      end
      if (free) begin
        if (pend_v) begin
          act = pend;
          pend_v = st;
          if (st) pend = snap;
        end else if (st) begin
          act = snap;
        end
      end else if (st) begin
        if (!pend_v) begin
          pend = snap;
          pend_v = 1'b1;
        end else if (m_drop != 8'hFF) begin
          m_drop = m_drop + 8'd1;
        end
      end
    end
    #1;
    chk("out_valid", out_valid, act.size() > 0);
    chk("out_data", out_data, (act.size() > 0) ? act[0] : 8'h00);
    chk("busy", busy, (act.size() > 0) || pend_v);
    chk("dropped", dropped, m_drop);
  endtask

  initial begin
    logic [7:0] exp1[8];
    logic [7:0] prev;
    logic       pv;
    bit         r;
    exp1 = '{8'hA5, 8'h00, 8'h12, 8'h34, 8'h01, 8'h02, 8'h03, 8'h04};

    // Reset state
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    chk("reset_valid", out_valid, 1'b0);
    chk("reset_data", out_data, 8'h00);
    chk("reset_busy", busy, 1'b0);
    chk("reset_dropped", dropped, 8'h00);

    // Single snapshot, continuous ready
    pc = 8'h12; ir = 8'h34; a = 8'h01; b = 8'h02; x = 8'h03; q = 8'h04;
    for (int k = 0; k < 8; k++) begin
      cyc(k == 0, 1'b1, 1'b0);
      chk("t1_byte", out_data, exp1[k]);
      chk("t1_valid", out_valid, 1'b1);
    end
`ifdef TRACE_CHECKSUM_EN
    cyc(1'b0, 1'b1, 1'b0);
    chk("t1_cksum", out_data, 8'h12 ^ 8'h34 ^ 8'h01 ^ 8'h02 ^ 8'h03 ^ 8'h04);
`endif
    cyc(1'b0, 1'b1, 1'b0);
    chk("t1_busy_low", busy, 1'b0);

    // Back-to-back steps: two frames contiguous, third dropped
    cyc(1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      rand_data();
      cyc(1'b1, 1'b1, 1'b0);
    end
    for (int k = 0; k < 20; k++) cyc(1'b0, 1'b1, 1'b0);
    chk("t2_dropped", dropped, 8'd1);
    rand_data();
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("t2_seq", out_data, 8'd3);
    for (int k = 0; k < 12; k++) cyc(1'b0, 1'b1, 1'b0);

    // Backpressure: ready toggles, bytes held while not ready
    cyc(1'b0, 1'b1, 1'b1);
    rand_data();
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 2 * 8; i++) begin
      r = (i % 2) == 0;
      prev = out_data;
      pv = out_valid;
      cyc(1'b0, r, 1'b0);
      if (!r && pv) chk("t3_hold", out_data, prev);
    end
`ifdef TRACE_CHECKSUM_EN
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
`endif
    chk("t3_done", busy, 1'b0);

    // Reset mid-frame
    cyc(1'b0, 1'b1, 1'b1);
    rand_data();
    cyc(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    chk("t4_valid_low", out_valid, 1'b0);
    rand_data();
    cyc(1'b1, 1'b1, 1'b0);
    chk("t4_header", out_data, 8'hA5);
    cyc(1'b0, 1'b1, 1'b0);
    chk("t4_seq", out_data, 8'h00);
    for (int k = 0; k < 10; k++) cyc(1'b0, 1'b1, 1'b0);

    // Drop counter saturation under a stalled sink
    cyc(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 300; k++) begin
      rand_data();
      cyc(1'b1, 1'b0, 1'b0);
    end
    chk("t5_dropped", dropped, 8'hFF);
    chk("t5_busy", busy, 1'b1);
    for (int k = 0; k < 2 * 9; k++) cyc(1'b0, 1'b1, 1'b0);
    chk("t5_drained", busy, 1'b0);

    // Randomized traffic against the model
    cyc(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 1500; k++) begin
      rand_data();
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
